timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev.sv | 111 +++++++++++
 tb/tb_timer_dev.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped down-counter timer with one-shot and
// auto-reload modes and a maskable, registered interrupt request.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic        ctrl_wr;
  logic        pre_wr;
  logic        reload;
  logic        set_flag;
  logic        en_n;
  logic [1:0]  mode_n;
  logic        im_n;
  logic        flag_n;

  // Next CTRL/flag values: the INT action first, then a CTRL
  // write overrides EN/MODE/IM, and a fresh expiry always sets the flag.
  always_comb begin
    ctrl_wr  = we && (addr == 2'b00);
    pre_wr   = we && (addr == 2'b01);
    reload   = (mode == 2'b01);
    set_flag = (state == CNT) && en && (count == 32'd0);
    en_n     = en;
    mode_n   = mode;
    im_n     = im;
    flag_n   = flag;
    if (state == INT) begin
      if (reload) flag_n = 1'b0;
      else        en_n   = 1'b0;
    end
    if (ctrl_wr) begin
      en_n   = din[0];
      mode_n = din[2:1];
      im_n   = din[3];
      if (din[0]) flag_n = 1'b0;
    end
    if (set_flag) flag_n = 1'b1;
  end

  // Registers, counter FSM and the registered interrupt output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      en   <= en_n;
      mode <= mode_n;
      im   <= im_n;
      flag <= flag_n;
      irq  <= im_n & flag_n;
      if (pre_wr) preset <= din;
      unique case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en)                 state <= IDLE;
          else if (count != 32'd0) count <= count - 32'd1;
          else                     state <= INT;
        end
        INT: begin
          state <= reload ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational read mux.
  always_comb begin
    dout = 32'd0;
    unique case (addr)
      2'b00:   dout = {28'd0, im, mode, en};
      2'b01:   dout = preset;
      2'b10:   dout = count;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev with a reference
// model, directed latency checks and randomized register traffic.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        q;
    int          id;
  } exp_t;

  exp_t q_exp[$];
  int   tests = 0;
  int   fails = 0;
  int   seq   = 0;

  // Reference model: phase 0 idle, 1 loading, 2 counting, 3 expired.
  int          m_ph;
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  logic        m_flag;
  logic        m_irq;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer's rules, applied to the model.
  task automatic model(input logic r, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
    int          ph;
    logic        en, im, fl;
    logic [1:0]  md;
    logic [31:0] cn;
    bit          expired;
    if (!r) begin
      m_ph = 0; m_en = 0; m_mode = 0; m_im = 0;
      m_pre = 0; m_cnt = 0; m_flag = 0; m_irq = 0;
      return;
    end
    ph = m_ph; en = m_en; md = m_mode; im = m_im;
    cn = m_cnt; fl = m_flag; expired = 0;
    if (m_ph == 0) begin
      if (m_en) ph = 1;
    end else if (m_ph == 1) begin
      cn = m_pre;
      ph = 2;
    end else if (m_ph == 2) begin
      if (!m_en) ph = 0;
      else if (m_cnt > 0) cn = m_cnt - 1;
      else begin ph = 3; expired = 1; end
    end else begin
      if (m_mode == 2'b01) begin ph = 1; fl = 0; end
      else begin ph = 0; en = 0; end
    end
    if (w && a == 2'd0) begin
      en = d[0]; md = d[2:1]; im = d[3];
      if (d[0]) fl = 0;
    end
    if (expired) fl = 1;
    if (w && a == 2'd1) m_pre = d;
    m_ph = ph; m_en = en; m_mode = md; m_im = im;
    m_cnt = cn; m_flag = fl;
    m_irq = im & fl;
  endtask

  // Drive one cycle, queue the expected post-edge response.
  task automatic step(input logic r, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    reset = r; we = w; addr = a; din = d;
    model(r, w, a, d);
    e.d = rd(a);
    e.q = m_irq;
    e.id = seq++;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Cycles until irq is seen high (bounded).
  task automatic gap(output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, 2'd2, 32'd0);
      n++;
    end while (!irq && n < 80);
  endtask

  // Monitor: pop and compare after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check($sformatf("dout[%0d]", e.id), dout, e.d);
        check($sformatf("irq[%0d]", e.id), {31'd0, irq}, {31'd0, e.q});
      end
    end
  end

  initial begin
    int n;
    int w;
    logic [1:0]  a;
    logic [31:0] d;
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;

    // Reset state on every register.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i[1:0], 32'd0);

    // One-shot: irq 8 cycles after enable, sticky, EN cleared.
    step(1'b1, 1'b1, 2'd1, 32'd5);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    gap(n);
    check("oneshot_latency", n, 8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i[1:0], 32'd0);
    check("oneshot_sticky", {31'd0, irq}, 32'd1);

    // Auto-reload: period of 6 with single-cycle pulses.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd1, 32'd3);
    step(1'b1, 1'b1, 2'd0, 32'hB);
    gap(n);
    check("reload_first", n, 6);
    for (int k = 0; k < 3; k++) begin
      gap(n);
      check("reload_period", n, 6);
    end

    // PRESET 0, ignored COUNT write, full-scale preset.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    gap(n);
    check("preset0_latency", n, 3);
    step(1'b1, 1'b1, 2'd2, 32'h1234);
    step(1'b1, 1'b1, 2'd3, 32'h5678);
    step(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'd2, 32'd0);

    // Masked expiry, then re-enable with mask clears the flag.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd1, 32'd2);
    step(1'b1, 1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 32'd0);

    // Pause and resume mid-count.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd1, 32'd14);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd2, 32'd0);
    step(1'b1, 1'b1, 2'd0, 32'h8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd2, 32'd0);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'd2, 32'd0);

    // Reset mid-count: no later interrupt.
    step(1'b0, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b1, 2'd1, 32'd10);
    step(1'b1, 1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd2, 32'd0);
    step(1'b0, 1'b0, 2'd2, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, i[1:0], 32'd0);

    // Randomized register traffic.
    for (int i = 0; i < 3000; i++) begin
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 9) == 0) ? 1 : 0;
      d = $urandom;
      if (a == 2'd1 && $urandom_range(0, 7) != 0)
        d = $urandom_range(0, 9);
      step(($urandom_range(0, 199) != 0), w[0], a, d);
    end

    n = 0;
    while (q_exp.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("queue_drained", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
